// File: rtl/async_fifo_wr_arb.sv
// Round-robin arbiter sharing one FIFO write port among NREQ requesters.
// The grant is held for a whole message, and each beat is tagged with its source ID.
module async_fifo_wr_arb #(
    parameter int NREQ   = 4,
    parameter int SRCW   = 2,
    parameter int DSIZE  = 8,
    parameter int MAXLEN = 16
) (
    input  logic                    wclk,
    input  logic                    wrst,
    input  logic [NREQ-1:0]         req_valid,
    input  logic [NREQ*DSIZE-1:0]   req_data,
    input  logic [NREQ-1:0]         req_last,
    output logic [NREQ-1:0]         req_ready,
    output logic                    fifo_winc,
    output logic [SRCW+DSIZE-1:0]   fifo_wdata,
    input  logic                    fifo_wfull,
    input  logic                    fifo_awfull,
    output logic                    busy,
    output logic [SRCW-1:0]         grant_id,
    output logic                    err_len
);

    localparam int CW = $clog2(MAXLEN + 1);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic {IDLE, LOCK} state_t;

    state_t          state;
    logic [SRCW-1:0] rr_ptr;
    logic [SRCW-1:0] owner;
    logic [CW-1:0]   beat_cnt;

    logic [NREQ-1:0]  own_sel;
    logic             own_valid;
    logic             own_last;
    logic [DSIZE-1:0] own_data;
    logic [SRCW-1:0]  winner;
    logic [IW-1:0]    pos;
    logic             found;
    logic             accept;
    logic             at_max;
    logic             release_msg;

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_sel
            assign own_sel[gi] = (owner == SRCW'(gi));
        end
    endgenerate

    always_comb begin
        own_valid = 1'b0;
        own_last  = 1'b0;
        own_data  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (own_sel[i]) begin
                own_valid = req_valid[i];
                own_last  = req_last[i];
                own_data  = req_data[i*DSIZE +: DSIZE];
            end
        end
    end

    // First valid requester at or after rr_ptr, wrapping modulo NREQ.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        pos    = '0;
        for (int k = 0; k < NREQ; k++) begin
            pos = IW'((int'(rr_ptr) + k) % NREQ);
            if (!found && req_valid[pos]) begin
                found  = 1'b1;
                winner = SRCW'(pos);
            end
        end
    end

    assign accept      = (state == LOCK) && own_valid && !fifo_wfull;
    assign at_max      = (beat_cnt == CW'(MAXLEN - 1));
    assign release_msg = accept && (own_last || at_max);

    assign req_ready  = ((state == LOCK) && !fifo_wfull) ? own_sel : '0;
    assign fifo_winc  = accept;
    assign fifo_wdata = {owner, own_data};
    assign busy       = (state == LOCK);
    assign grant_id   = owner;

    always_ff @(posedge wclk or posedge wrst) begin
        if (wrst) begin
            state    <= IDLE;
            rr_ptr   <= '0;
            owner    <= '0;
            beat_cnt <= '0;
            err_len  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (found && !fifo_awfull && !fifo_wfull) begin
                        owner    <= winner;
                        beat_cnt <= '0;
                        state    <= LOCK;
                    end
                end
                LOCK: begin
                    if (accept) begin
                        beat_cnt <= beat_cnt + CW'(1);
                    end
                    if (release_msg) begin
                        state  <= IDLE;
                        rr_ptr <= (owner == SRCW'(NREQ - 1)) ? '0 : owner + SRCW'(1);
                        // Forced release: the tail is re-arbitrated as a fresh message.
                        if (!own_last) begin
                            err_len <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_async_fifo_wr_arb.sv
// Directed bench for async_fifo_wr_arb: a cycle table followed by multi-cycle
// sequences (fairness, full stall, length limit, reset mid-message).
module tb_async_fifo_wr_arb;

    logic        wclk;
    logic        wrst;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_last;
    logic [3:0]  req_ready;
    logic        fifo_winc;
    logic [9:0]  fifo_wdata;
    logic        fifo_wfull;
    logic        fifo_awfull;
    logic        busy;
    logic [1:0]  grant_id;
    logic        err_len;

    int checks = 0;
    int errors = 0;

    async_fifo_wr_arb #(.NREQ(4), .SRCW(2), .DSIZE(8), .MAXLEN(16)) dut (
        .wclk        (wclk),
        .wrst        (wrst),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_last    (req_last),
        .req_ready   (req_ready),
        .fifo_winc   (fifo_winc),
        .fifo_wdata  (fifo_wdata),
        .fifo_wfull  (fifo_wfull),
        .fifo_awfull (fifo_awfull),
        .busy        (busy),
        .grant_id    (grant_id),
        .err_len     (err_len)
    );

    initial wclk = 1'b0;
    always #5 wclk = ~wclk;

    typedef struct {
        logic [3:0]  valid;
        logic [3:0]  last;
        logic [31:0] data;
        logic        wfull;
        logic        awfull;
        logic [3:0]  e_ready;
        logic        e_winc;
        logic [9:0]  e_wdata;
        logic        e_busy;
        logic [1:0]  e_grant;
    } vec_t;

    vec_t      vecs[$];
    logic [9:0] wr_data_q[$];
    int         wr_cyc_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic [3:0] v, input logic [3:0] l, input logic [31:0] d,
                       input logic wf, input logic af, input logic [3:0] er, input logic ew,
                       input logic [9:0] ed, input logic eb, input logic [1:0] eg);
        vec_t x;
        x.valid = v;  x.last = l;  x.data = d;  x.wfull = wf;  x.awfull = af;
        x.e_ready = er;  x.e_winc = ew;  x.e_wdata = ed;  x.e_busy = eb;  x.e_grant = eg;
        vecs.push_back(x);
    endtask

    task automatic reset_dut();
        wrst = 1'b1;
        req_valid = '0;  req_last = '0;  fifo_wfull = 1'b0;  fifo_awfull = 1'b0;
        repeat (2) @(posedge wclk);
        #1 wrst = 1'b0;
    endtask

    // Drives one requester through a message, recording every FIFO write and its cycle.
    task automatic run_msg(input int src, input int nbeats, input int base,
                           input int stall_beat, input int stall_len);
        int   beat;
        int   cyc;
        int   stall_left;
        logic acc;
        wr_data_q.delete();
        wr_cyc_q.delete();
        beat = 0;  cyc = 0;  stall_left = stall_len;
        while (beat < nbeats && cyc < 300) begin
            req_valid  = 4'(1 << src);
            req_last   = (beat == nbeats - 1) ? 4'(1 << src) : 4'b0;
            req_data   = 32'((base + beat) & 255) << (8 * src);
            fifo_wfull = (beat == stall_beat) && (stall_left > 0);
            @(negedge wclk);
            if (fifo_wfull) begin
                chk("stall_ready", 32'(req_ready), 32'h0);
                chk("stall_winc", 32'(fifo_winc), 32'h0);
                stall_left--;
            end
            if (fifo_winc) begin
                wr_data_q.push_back(fifo_wdata);
                wr_cyc_q.push_back(cyc);
            end
            acc = |(req_ready & req_valid);
            @(posedge wclk);
            #1;
            if (acc) beat++;
            cyc++;
        end
        req_valid = '0;  req_last = '0;  fifo_wfull = 1'b0;
        chk("msg_timeout", 32'(beat), 32'(nbeats));
        $display("msg src=%0d beats=%0d writes=%0d cycles=%0d", src, nbeats, wr_data_q.size(), cyc);
    endtask

    task automatic check_msg(input int src, input int nbeats, input int base,
                             input int stall_beat, input int stall_len, input int split_beat);
        int gap;
        chk("beat_count", 32'(wr_data_q.size()), 32'(nbeats));
        for (int k = 0; k < nbeats && k < wr_data_q.size(); k++) begin
            chk("beat_data", 32'(wr_data_q[k]), 32'({2'(src), 8'((base + k) & 255)}));
            if (k > 0) begin
                gap = 1 + ((k == stall_beat) ? stall_len : 0) + ((k == split_beat) ? 1 : 0);
                chk("beat_gap", 32'(wr_cyc_q[k] - wr_cyc_q[k-1]), 32'(gap));
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        wrst = 1'b1;
        req_valid = '0;  req_last = '0;  req_data = 32'h0000_005A;
        fifo_wfull = 1'b0;  fifo_awfull = 1'b0;
        reset_dut();

        // Reset values
        @(negedge wclk);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_grant", 32'(grant_id), 32'h0);
        chk("rst_ready", 32'(req_ready), 32'h0);
        chk("rst_winc", 32'(fifo_winc), 32'h0);
        chk("rst_wdata", 32'(fifo_wdata), 32'h05A);
        chk("rst_err", 32'(err_len), 32'h0);
        @(posedge wclk);
        #1;

        // Arbitration order, pointer wrap, almost-full and full gating
        //   valid    last     data           wf  af  ready    winc wdata    busy grant
        add(4'b0101, 4'b0000, 32'h0020_0010, 0, 0, 4'b0000, 0, 10'h010, 0, 2'd0);
        add(4'b0101, 4'b0000, 32'h0020_0010, 0, 0, 4'b0001, 1, 10'h010, 1, 2'd0);
        add(4'b0101, 4'b0000, 32'h0020_0011, 0, 0, 4'b0001, 1, 10'h011, 1, 2'd0);
        add(4'b0101, 4'b0001, 32'h0020_0012, 0, 0, 4'b0001, 1, 10'h012, 1, 2'd0);
        add(4'b0100, 4'b0000, 32'h0020_0012, 0, 0, 4'b0000, 0, 10'h012, 0, 2'd0);
        add(4'b0100, 4'b0000, 32'h0020_0012, 0, 0, 4'b0100, 1, 10'h220, 1, 2'd2);
        add(4'b0100, 4'b0000, 32'h0021_0012, 0, 0, 4'b0100, 1, 10'h221, 1, 2'd2);
        add(4'b0100, 4'b0100, 32'h0022_0012, 0, 0, 4'b0100, 1, 10'h222, 1, 2'd2);
        add(4'b1001, 4'b1001, 32'h4022_0030, 0, 0, 4'b0000, 0, 10'h222, 0, 2'd2);
        add(4'b1001, 4'b1001, 32'h4022_0030, 0, 0, 4'b1000, 1, 10'h340, 1, 2'd3);
        add(4'b0001, 4'b0001, 32'h4022_0030, 0, 0, 4'b0000, 0, 10'h340, 0, 2'd3);
        add(4'b0001, 4'b0001, 32'h4022_0030, 0, 0, 4'b0001, 1, 10'h030, 1, 2'd0);
        add(4'b0000, 4'b0000, 32'h4022_0030, 0, 0, 4'b0000, 0, 10'h030, 0, 2'd0);
        add(4'b0010, 4'b0010, 32'h4022_5030, 0, 1, 4'b0000, 0, 10'h030, 0, 2'd0);
        add(4'b0010, 4'b0010, 32'h4022_5030, 0, 1, 4'b0000, 0, 10'h030, 0, 2'd0);
        add(4'b0010, 4'b0010, 32'h4022_5030, 0, 0, 4'b0000, 0, 10'h030, 0, 2'd0);
        add(4'b0010, 4'b0010, 32'h4022_5030, 0, 0, 4'b0010, 1, 10'h150, 1, 2'd1);
        add(4'b0000, 4'b0000, 32'h4022_5030, 0, 0, 4'b0000, 0, 10'h150, 0, 2'd1);
        add(4'b0010, 4'b0010, 32'h4022_5030, 1, 0, 4'b0000, 0, 10'h150, 0, 2'd1);
        add(4'b0010, 4'b0010, 32'h4022_5030, 0, 0, 4'b0000, 0, 10'h150, 0, 2'd1);
        add(4'b0010, 4'b0010, 32'h4022_5030, 0, 1, 4'b0010, 1, 10'h150, 1, 2'd1);
        add(4'b0000, 4'b0000, 32'h4022_5030, 0, 0, 4'b0000, 0, 10'h150, 0, 2'd1);

        for (int i = 0; i < vecs.size(); i++) begin
            req_valid = vecs[i].valid;  req_last = vecs[i].last;  req_data = vecs[i].data;
            fifo_wfull = vecs[i].wfull;  fifo_awfull = vecs[i].awfull;
            @(negedge wclk);
            $display("vec %0d: ready=%b winc=%0b wdata=%h busy=%0b grant=%0d",
                     i, req_ready, fifo_winc, fifo_wdata, busy, grant_id);
            chk("vec_ready", 32'(req_ready), 32'(vecs[i].e_ready));
            chk("vec_winc", 32'(fifo_winc), 32'(vecs[i].e_winc));
            chk("vec_wdata", 32'(fifo_wdata), 32'(vecs[i].e_wdata));
            chk("vec_busy", 32'(busy), 32'(vecs[i].e_busy));
            chk("vec_grant", 32'(grant_id), 32'(vecs[i].e_grant));
            chk("vec_err", 32'(err_len), 32'h0);
            @(posedge wclk);
            #1;
        end
        fifo_wfull = 1'b0;  fifo_awfull = 1'b0;

        // Fairness: all requesters always valid with single-beat messages
        reset_dut();
        req_valid = 4'b1111;  req_last = 4'b1111;  req_data = 32'h6362_6160;
        for (int c = 0; c < 10; c++) begin
            @(negedge wclk);
            $display("fair cycle %0d: winc=%0b grant=%0d wdata=%h", c, fifo_winc, grant_id, fifo_wdata);
            chk("fair_winc", 32'(fifo_winc), 32'(c % 2));
            if (c % 2 == 1) begin
                chk("fair_grant", 32'(grant_id), 32'((c / 2) % 4));
                chk("fair_wdata", 32'(fifo_wdata), 32'({2'((c / 2) % 4), 8'(8'h60 + (c / 2) % 4)}));
            end
            @(posedge wclk);
            #1;
        end
        req_valid = '0;  req_last = '0;

        // Full stall for 5 cycles on beat 2 of a 4-beat message
        reset_dut();
        run_msg(1, 4, 8'h70, 1, 5);
        check_msg(1, 4, 8'h70, 1, 5, -1);
        chk("stall_err", 32'(err_len), 32'h0);

        // Length limit: 20 beats with last only on beat 20
        run_msg(3, 20, 8'h90, -1, 0);
        check_msg(3, 20, 8'h90, -1, 0, 16);
        @(negedge wclk);
        chk("len_err", 32'(err_len), 32'h1);
        chk("len_busy", 32'(busy), 32'h0);
        @(posedge wclk);
        #1;

        // Reset pulsed during beat 2
        req_valid = 4'b0100;  req_last = 4'b0000;  req_data = 32'h0080_0000;
        @(negedge wclk);
        @(posedge wclk);
        #1;
        @(negedge wclk);
        chk("mid_beat1_winc", 32'(fifo_winc), 32'h1);
        @(posedge wclk);
        #1;
        req_data = 32'h0081_0000;
        wrst = 1'b1;
        @(negedge wclk);
        chk("mid_rst_winc", 32'(fifo_winc), 32'h0);
        chk("mid_rst_busy", 32'(busy), 32'h0);
        @(posedge wclk);
        #1;
        wrst = 1'b0;
        req_valid = 4'b1001;  req_last = 4'b1001;  req_data = 32'hA000_00B0;
        @(negedge wclk);
        chk("post_rst_busy", 32'(busy), 32'h0);
        chk("post_rst_err", 32'(err_len), 32'h0);
        @(posedge wclk);
        #1;
        @(negedge wclk);
        $display("post reset grant=%0d wdata=%h", grant_id, fifo_wdata);
        chk("post_rst_grant", 32'(grant_id), 32'h0);
        chk("post_rst_wdata", 32'(fifo_wdata), 32'h0B0);
        @(posedge wclk);
        #1;
        req_valid = '0;  req_last = '0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/async_fifo_wr_arb.md
# async_fifo_wr_arb

Round-robin write-side arbiter that shares the single write port of one `async_fifo` instance among NREQ requesters in the write clock domain. Each requester streams multi-beat messages over a valid/ready/last handshake. The arbiter locks the grant for a whole message and tags every beat with its source ID. It starts a new message only when the FIFO has headroom (`awfull` low), and it bounds message length so that a broken requester cannot hold the port forever.

## Interface
- NREQ, 4, number of requesters (2..16)
- SRCW, 2, source-ID width; NREQ <= 2**SRCW
- DSIZE, 8, payload width per beat
- MAXLEN, 16, maximum beats per message before a forced release (>=1)

- wclk  in  1  write-domain clock; all state on rising edge
- wrst  in  1  reset, asynchronous assert, active-high
- req_valid  in  NREQ  per-requester beat valid
- req_data  in  NREQ*DSIZE  per-requester payload; requester i occupies bits [i*DSIZE +: DSIZE]
- req_last  in  NREQ  marks the final beat of a message
- req_ready  out  NREQ  beat accepted when `req_valid[i] & req_ready[i]`
- fifo_winc  out  1  to the FIFO `winc`
- fifo_wdata  out  SRCW+DSIZE  to the FIFO `wdata`; {owner ID, payload}
- fifo_wfull  in  1  FIFO `wfull`
- fifo_awfull  in  1  FIFO `awfull`
- busy  out  1  a message is locked
- grant_id  out  SRCW  current or last owner
- err_len  out  1  sticky; set when a message is force-released at MAXLEN

## Operation
- **FSM states:** IDLE and LOCK.
- **Registers:** `rr_ptr` (SRCW bits), `owner` (SRCW bits), `beat_cnt` (clog2(MAXLEN+1) bits), `err_len`.
- **IDLE:**
  - Arbitration fires when any `req_valid` is high and `fifo_awfull` and `fifo_wfull` are both low.
  - The winner is the first valid index at or after `rr_ptr`, searching upward modulo NREQ.
  - On the next edge: `owner` <= winner, `beat_cnt` <= 0, state <= LOCK.
  - No beat is transferred in the arbitration cycle. `req_ready` is all-zero in IDLE.
- **LOCK:**
  - `req_ready[owner] = !fifo_wfull`; every other `req_ready` bit is 0 (combinational).
  - `fifo_winc = req_valid[owner] & !fifo_wfull`.
  - `fifo_wdata = {owner, req_data[owner]}`.
  - Each accepted beat increments `beat_cnt`.
  - Release happens on an accepted beat when `req_last[owner]` is 1, or when `beat_cnt == MAXLEN-1`.
  - On release the next edge gives: state <= IDLE, `rr_ptr` <= (owner+1) mod NREQ.
  - If the release is due to MAXLEN and `req_last` is 0, `err_len` <= 1 and the remainder of that message is treated as a new message.
- **Stalls:**
  - The owner deasserting `req_valid` mid-message leaves the lock held indefinitely.
  - `fifo_wfull` rising mid-message stalls the handshake (`req_ready` drops the same cycle); no beat is lost or duplicated.
  - `fifo_awfull` is ignored inside LOCK; it gates only message start.
- **Outputs:** `busy` = (state==LOCK). `grant_id` = `owner`.
- `err_len` is cleared only by `wrst`.

## Timing
- **Reset values:** state=IDLE, `rr_ptr`=0, `owner`=0, `beat_cnt`=0, `err_len`=0. This gives `busy`=0, `grant_id`=0, `req_ready`=0, `fifo_winc`=0, `fifo_wdata`={0, `req_data[0]`}.
- Reset asserted mid-message aborts the message immediately. No further `fifo_winc` is issued; the partial message already in the FIFO stays there.
- **Latency:** request to first accepted beat is 1 cycle when the FIFO is not full (arbitrate edge, then transfer).
- **Throughput:** 1 beat/cycle inside a message. Exactly one IDLE cycle separates consecutive messages.
- **Combinational paths:** the `req_valid`/`req_data` -> `fifo_winc`/`fifo_wdata` path and the `fifo_wfull` -> `req_ready` path are both combinational. This is intentional, so that the FIFO full flag applies in the same cycle.
- A single-beat message (`last` on the first beat) occupies LOCK for exactly 1 cycle.
- With MAXLEN=1, every beat is its own message. `err_len` is set whenever `last` is 0.
- **Pointer wrap:** `rr_ptr` wraps from NREQ-1 to 0. Indices at or above NREQ are never granted.

## Test plan
- **Arbitration order:** Requesters 0 and 2 each present a 3-beat message at cycle 0 after reset -> grant 0 at cycle 1, beats written cycles 1-3 with tag 0, IDLE at cycle 4, grant 2, tag-2 beats at cycles 5-7, `rr_ptr`=3 at the end.
- **Fairness:** All 4 requesters hold valid continuously with 1-beat messages -> grant order 0,1,2,3,0, one write every 2 cycles.
- **Full stall:** `fifo_wfull` forced high for 5 cycles during beat 2 of a 4-beat message -> `req_ready`/`fifo_winc` low for those 5 cycles, all 4 beats written exactly once and in order.
- **Almost-full gating:** `fifo_awfull`=1 with requester 1 valid -> stays IDLE, `busy`=0. `awfull` drops -> grant 1 on the next edge.
- **Length limit:** MAXLEN=16, requester 3 streams 20 beats with `last` only on beat 20 -> release after beat 16, `err_len`=1, the remaining 4 beats are re-arbitrated as a new message.
- **Reset mid-message:** `wrst` pulsed during beat 2 of a message -> `fifo_winc` 0 the same cycle. After deassertion the block is in IDLE with `rr_ptr`=0 and `err_len`=0.
